// File: rtl/operand_select_pipe_pkg.sv
// Shared operand-select encodings and default widths for the decode, operand and ALU stages.
package operand_select_pipe_pkg;

   typedef enum logic [1:0] {
      OPSEL_REG   = 2'b00,
      OPSEL_NEG   = 2'b01,
      OPSEL_IMM_Z = 2'b10,
      OPSEL_IMM_S = 2'b11
   } opsel_e;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_IMM_WIDTH  = 8;

endpackage

// File: rtl/operand_transform.sv
// Combinational operand source select and transform; also used by the branch-offset path.
module operand_transform
   import operand_select_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH
) (
   input  logic [1:0]            sel_i,
   input  logic [DATA_WIDTH-1:0] reg_data_i,
   input  logic [IMM_WIDTH-1:0]  imm_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  ovf_o
);

   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0] neg_data;
   logic [DATA_WIDTH-1:0] imm_zext;
   logic [DATA_WIDTH-1:0] imm_sext;

   assign neg_data = ~reg_data_i + DATA_WIDTH'(1);
   assign imm_zext = DATA_WIDTH'(imm_i);
   assign imm_sext = DATA_WIDTH'($signed(imm_i));

   always_comb begin
      data_o = reg_data_i;
      ovf_o  = 1'b0;
      case (opsel_e'(sel_i))
         OPSEL_REG:   data_o = reg_data_i;
         OPSEL_NEG: begin
            // The most negative value wraps onto itself; flag it for the ALU.
            data_o = neg_data;
            ovf_o  = (reg_data_i == MOST_NEG);
         end
         OPSEL_IMM_Z: data_o = imm_zext;
         OPSEL_IMM_S: data_o = imm_sext;
         default:     data_o = reg_data_i;
      endcase
   end

endmodule

// File: rtl/operand_select_pipe.sv
// Registered operand-B selector: transform, then a valid/ready stage with a one-entry skid register.
module operand_select_pipe
   import operand_select_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [DATA_WIDTH-1:0] REG_DATA,
   input  logic [IMM_WIDTH-1:0]  IMMEDIATE,
   input  logic [1:0]            SEL,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic [1:0]            OUT_SEL,
   output logic                  NEG_OVF
);

   if (DATA_WIDTH < 2 || DATA_WIDTH > 32 || IMM_WIDTH < 1 || IMM_WIDTH > DATA_WIDTH) begin : g_param_err
      $error("operand_select_pipe: illegal DATA_WIDTH/IMM_WIDTH combination");
   end

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            sel;
      logic                  ovf;
   } slot_t;

   logic [DATA_WIDTH-1:0] xform_data;
   logic                  xform_ovf;
   slot_t                 in_slot;
   slot_t                 main_q, main_d;
   slot_t                 skid_q, skid_d;
   logic                  main_valid_q, main_valid_d;
   logic                  skid_valid_q, skid_valid_d;
   logic                  in_xfer;
   logic                  main_free;

   operand_transform #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMM_WIDTH  (IMM_WIDTH)
   ) u_transform (
      .sel_i      (SEL),
      .reg_data_i (REG_DATA),
      .imm_i      (IMMEDIATE),
      .data_o     (xform_data),
      .ovf_o      (xform_ovf)
   );

   assign in_slot   = '{data: xform_data, sel: SEL, ovf: xform_ovf};
   assign in_xfer   = IN_VALID & ~skid_valid_q;
   // Main register can take a new item when empty or being drained this cycle.
   assign main_free = ~main_valid_q | OUT_READY;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (main_free) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            main_d       = in_slot;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_d       = in_slot;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign IN_READY  = ~skid_valid_q;
   assign OUT_VALID = main_valid_q;
   assign OUT_DATA  = main_q.data;
   assign OUT_SEL   = main_q.sel;
   assign NEG_OVF   = main_q.ovf;

endmodule

// File: tb/tb_operand_select_pipe.sv
// Randomised self-checking bench for operand_select_pipe against a 2-deep FIFO reference model.
module tb_operand_select_pipe;

   localparam int DW = 8;
   localparam int IW = 4;

   logic          CLK       = 1'b0;
   logic          RESET     = 1'b1;
   logic          IN_VALID  = 1'b0;
   logic          OUT_READY = 1'b0;
   logic [DW-1:0] REG_DATA  = '0;
   logic [IW-1:0] IMMEDIATE = '0;
   logic [1:0]    SEL       = 2'b00;
   logic          IN_READY;
   logic          OUT_VALID;
   logic          NEG_OVF;
   logic [DW-1:0] OUT_DATA;
   logic [1:0]    OUT_SEL;

   typedef struct packed {
      logic          ovf;
      logic [1:0]    sel;
      logic [DW-1:0] data;
   } item_t;

   item_t q[$];
   int    total = 0;
   int    bad   = 0;

   operand_select_pipe #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .REG_DATA  (REG_DATA),
      .IMMEDIATE (IMMEDIATE),
      .SEL       (SEL),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_SEL   (OUT_SEL),
      .NEG_OVF   (NEG_OVF)
   );

   always #5 CLK = ~CLK;

   // Arithmetic reference for the operand transform.
   function automatic item_t model(input logic [1:0] s, input logic [DW-1:0] r, input logic [IW-1:0] im);
      item_t it;
      int    v;
      it.sel = s;
      it.ovf = 1'b0;
      case (s)
         2'd0: v = int'(r);
         2'd1: begin
            v      = ((2 ** DW) - int'(r)) % (2 ** DW);
            it.ovf = (int'(r) == 2 ** (DW - 1));
         end
         2'd2: v = int'(im);
         default: v = (int'(im) >= 2 ** (IW - 1)) ? int'(im) + (2 ** DW) - (2 ** IW) : int'(im);
      endcase
      it.data = v[DW-1:0];
      return it;
   endfunction

   // One clock: the stage behaves as a 2-entry FIFO, ready while fewer than 2 items are held.
   task automatic tick();
      bit    in_fire;
      bit    out_fire;
      item_t nw;
      in_fire  = IN_VALID && (q.size() < 2);
      out_fire = (q.size() > 0) && OUT_READY;
      nw       = model(SEL, REG_DATA, IMMEDIATE);
      @(posedge CLK);
      #1;
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(nw);
   endtask

   task automatic drive_rand();
      SEL       = 2'($urandom_range(0, 3));
      REG_DATA  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      IMMEDIATE = 4'($urandom);
   endtask

   task automatic test_reset();
      #1 RESET = 1'b0;
      #1;
      total++;
      if ({OUT_VALID, IN_READY, OUT_SEL, NEG_OVF, OUT_DATA} !== {1'b0, 1'b1, 2'b00, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset_state: got v=%b rdy=%b sel=%b ovf=%b data=%h want v=0 rdy=1 sel=00 ovf=0 data=00",
                  OUT_VALID, IN_READY, OUT_SEL, NEG_OVF, OUT_DATA);
      end
      @(posedge CLK);
      @(posedge CLK);
      #3 RESET = 1'b1;
   endtask

   task automatic test_transforms();
      logic [1:0]    ts[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
      logic [DW-1:0] tr[5] = '{8'h5A, 8'h05, 8'h33, 8'hC4, 8'h80};
      logic [IW-1:0] ti[5] = '{4'h3, 4'hF, 4'hA, 4'hA, 4'h7};
      logic [DW-1:0] td[5] = '{8'h5A, 8'hFB, 8'h0A, 8'hFA, 8'h07};
      for (int i = 0; i < 5; i++) begin
         SEL = ts[i]; REG_DATA = tr[i]; IMMEDIATE = ti[i];
         IN_VALID = 1'b1; OUT_READY = 1'b1;
         tick();
         IN_VALID = 1'b0;
         REG_DATA = 8'($urandom); IMMEDIATE = 4'($urandom);
         total++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== td[i] || NEG_OVF !== 1'b0 || OUT_SEL !== ts[i]) begin
            bad++;
            $display("FAIL transform_%0d: got v=%b data=%h sel=%b ovf=%b want v=1 data=%h sel=%b ovf=0",
                     i, OUT_VALID, OUT_DATA, OUT_SEL, NEG_OVF, td[i], ts[i]);
         end
         total++;
         if (q.size() != 1 || {NEG_OVF, OUT_SEL, OUT_DATA} !== q[0]) begin
            bad++;
            $display("FAIL transform_model_%0d: got %h want %h", i, {NEG_OVF, OUT_SEL, OUT_DATA},
                     (q.size() > 0) ? q[0] : item_t'('0));
         end
         tick();
      end
      total++;
      if (OUT_VALID !== 1'b0) begin
         bad++;
         $display("FAIL transform_drain: got v=%b want v=0", OUT_VALID);
      end
   endtask

   task automatic test_neg_ovf();
      logic [DW-1:0] rv[2] = '{8'h80, 8'h01};
      logic [DW-1:0] dv[2] = '{8'h80, 8'hFF};
      logic          ov[2] = '{1'b1, 1'b0};
      OUT_READY = 1'b1;
      SEL = 2'b01;
      for (int i = 0; i < 2; i++) begin
         REG_DATA = rv[i]; IN_VALID = 1'b1;
         tick();
         total++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== dv[i] || NEG_OVF !== ov[i]) begin
            bad++;
            $display("FAIL neg_ovf_%0d: got v=%b data=%h ovf=%b want v=1 data=%h ovf=%b",
                     i, OUT_VALID, OUT_DATA, NEG_OVF, dv[i], ov[i]);
         end
      end
      IN_VALID = 1'b0;
      tick();
   endtask

   task automatic test_back_pressure();
      logic [DW-1:0] vals[3] = '{8'h11, 8'h22, 8'h33};
      logic          rdy[3]  = '{1'b1, 1'b0, 1'b0};
      OUT_READY = 1'b0; SEL = 2'b00;
      for (int i = 0; i < 3; i++) begin
         REG_DATA = vals[i]; IN_VALID = 1'b1;
         tick();
         total++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h11 || IN_READY !== rdy[i]) begin
            bad++;
            $display("FAIL bp_fill_%0d: got v=%b data=%h rdy=%b want v=1 data=11 rdy=%b",
                     i, OUT_VALID, OUT_DATA, IN_READY, rdy[i]);
         end
      end
      OUT_READY = 1'b1;
      for (int i = 1; i < 3; i++) begin
         tick();
         if (i == 2) IN_VALID = 1'b0;
         total++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== vals[i] || IN_READY !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain_%0d: got v=%b data=%h rdy=%b want v=1 data=%h rdy=1",
                     i, OUT_VALID, OUT_DATA, IN_READY, vals[i]);
         end
      end
      tick();
      total++;
      if (OUT_VALID !== 1'b0 || q.size() != 0) begin
         bad++;
         $display("FAIL bp_empty: got v=%b model=%0d want v=0 model=0", OUT_VALID, q.size());
      end
   endtask

   task automatic test_throughput();
      int outs = 0;
      IN_VALID = 1'b1; OUT_READY = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive_rand();
         tick();
         if (OUT_VALID === 1'b1) outs++;
         total++;
         if (IN_READY !== 1'b1 || OUT_VALID !== 1'b1 || q.size() != 1 || {NEG_OVF, OUT_SEL, OUT_DATA} !== q[0]) begin
            bad++;
            $display("FAIL throughput_%0d: got rdy=%b v=%b item=%h want rdy=1 v=1 item=%h", i, IN_READY,
                     OUT_VALID, {NEG_OVF, OUT_SEL, OUT_DATA}, (q.size() > 0) ? q[0] : item_t'('0));
         end
      end
      IN_VALID = 1'b0;
      tick();
      total++;
      if (outs != 16 || OUT_VALID !== 1'b0) begin
         bad++;
         $display("FAIL throughput_count: got outs=%0d v=%b want outs=16 v=0", outs, OUT_VALID);
      end
   endtask

   task automatic test_random_stall();
      bit    stalled;
      item_t held;
      int    guard;
      for (int c = 0; c < 1000; c++) begin
         IN_VALID  = ($urandom_range(0, 9) < 7);
         OUT_READY = ($urandom_range(0, 9) < 5);
         drive_rand();
         stalled = OUT_VALID && !OUT_READY;
         held    = {NEG_OVF, OUT_SEL, OUT_DATA};
         tick();
         total++;
         if (OUT_VALID !== (q.size() > 0) || IN_READY !== (q.size() < 2)) begin
            bad++;
            $display("FAIL rand_flags_%0d: got v=%b rdy=%b want v=%b rdy=%b", c, OUT_VALID, IN_READY,
                     q.size() > 0, q.size() < 2);
         end else if (q.size() > 0) begin
            total++;
            if ({NEG_OVF, OUT_SEL, OUT_DATA} !== q[0]) begin
               bad++;
               $display("FAIL rand_item_%0d: got %h want %h", c, {NEG_OVF, OUT_SEL, OUT_DATA}, q[0]);
            end
         end
         if (stalled) begin
            total++;
            if ({NEG_OVF, OUT_SEL, OUT_DATA} !== held) begin
               bad++;
               $display("FAIL rand_stable_%0d: got %h want %h", c, {NEG_OVF, OUT_SEL, OUT_DATA}, held);
            end
         end
      end
      IN_VALID = 1'b0; OUT_READY = 1'b1;
      guard = 0;
      while (q.size() > 0 && guard < 4) begin
         total++;
         if ({OUT_VALID, NEG_OVF, OUT_SEL, OUT_DATA} !== {1'b1, q[0]}) begin
            bad++;
            $display("FAIL rand_tail: got v=%b item=%h want v=1 item=%h", OUT_VALID,
                     {NEG_OVF, OUT_SEL, OUT_DATA}, q[0]);
         end
         tick();
         guard++;
      end
      total++;
      if (q.size() != 0 || OUT_VALID !== 1'b0) begin
         bad++;
         $display("FAIL rand_drain: got v=%b model=%0d want v=0 model=0", OUT_VALID, q.size());
      end
   endtask

   task automatic test_async_reset();
      OUT_READY = 1'b0; SEL = 2'b01; IN_VALID = 1'b1;
      REG_DATA = 8'h80; tick();
      REG_DATA = 8'h44; tick();
      total++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
         bad++;
         $display("FAIL areset_full: got rdy=%b v=%b want rdy=0 v=1", IN_READY, OUT_VALID);
      end
      #2 RESET = 1'b0;
      #1;
      q.delete();
      total++;
      if ({OUT_VALID, IN_READY, OUT_SEL, NEG_OVF, OUT_DATA} !== {1'b1 ^ 1'b1, 1'b1, 2'b00, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL areset_immediate: got v=%b rdy=%b sel=%b ovf=%b data=%h want v=0 rdy=1 sel=00 ovf=0 data=00",
                  OUT_VALID, IN_READY, OUT_SEL, NEG_OVF, OUT_DATA);
      end
      @(posedge CLK);
      @(posedge CLK);
      #3 RESET = 1'b1;
      SEL = 2'b11; IMMEDIATE = 4'h9;
      tick();
      IN_VALID = 1'b0;
      total++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hF9 || IN_READY !== 1'b1 || q.size() != 1) begin
         bad++;
         $display("FAIL areset_first: got v=%b data=%h rdy=%b want v=1 data=f9 rdy=1", OUT_VALID, OUT_DATA, IN_READY);
      end
      tick();
      total++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hF9) begin
         bad++;
         $display("FAIL areset_hold: got v=%b data=%h want v=1 data=f9", OUT_VALID, OUT_DATA);
      end
      OUT_READY = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_transforms();
      test_neg_ovf();
      test_back_pressure();
      test_throughput();
      test_random_stall();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout: got no finish want finish within 200000ns");
      $fatal(1, "timeout");
   end

endmodule
